dino_pixel_renderer: RTL



---
 rtl/dino_gfx_pkg.sv | 46 ++++
 rtl/dino_pixel_renderer_if.sv | 24 ++
 rtl/dino_sprite_rom.sv | 22 ++
 rtl/dino_pixel_renderer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dino_gfx_pkg.sv
// Shared graphics constants for the dino renderer: sprite geometry, colours, sprite art.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dino_gfx_pkg;

    localparam int DINO_W = 32;
    localparam int DINO_H = 32;
    localparam int OBS_W  = 16;
    localparam int OBS_H  = 32;

    typedef struct packed {
        logic [9:0] red;
        logic [9:0] green;
        logic [9:0] blue;
    } rgb_t;

    localparam rgb_t COL_BG     = '{red: 10'h3FF, green: 10'h3FF, blue: 10'h3FF};
    localparam rgb_t COL_GND    = '{red: 10'h200, green: 10'h200, blue: 10'h200};
    localparam rgb_t COL_DINO   = '{red: 10'h155, green: 10'h155, blue: 10'h155};
    localparam rgb_t COL_OVER_R = '{red: 10'h3FF, green: 10'h000, blue: 10'h000};
    localparam rgb_t COL_OBS_G  = '{red: 10'h000, green: 10'h2A0, blue: 10'h000};

    // Dino art, address {phase, dy[4:0], dx[4:0]}: body occupies columns 8..31;
    // in the bottom 8 rows only alternating 4-column leg stripes are drawn, and
    // which stripes are lit flips with the animation phase.
    function automatic logic dinoPixel(input logic [10:0] addr);
        logic       phase;
        logic [4:0] dy;
        logic [4:0] dx;
        phase = addr[10];
        dy    = addr[9:5];
        dx    = addr[4:0];
        return (dx >= 5'd8) && ((dy < 5'd24) || (dx[2] == phase));
    endfunction

    // Cactus art, address {dy[4:0], dx[3:0]}: trunk in columns 4..11 on every
    // row, plus full-width arms on rows 16..23.
    function automatic logic obsPixel(input logic [8:0] addr);
        logic [4:0] dy;
        logic [3:0] dx;
        dy = addr[8:4];
        dx = addr[3:0];
        return (dx[3:2] == 2'b01) || (dx[3:2] == 2'b10) || (dy[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/dino_pixel_renderer_if.sv
// Pixel bus between the VGA controller / game logic (master) and the renderer (slave).
// Latency: n/a (wires only).
// Backpressure: none; one pixel coordinate per clock, RGB returned two clocks later.
interface dino_pixel_renderer_if;
    logic [9:0] iCoord_X;     // active-area column 0..639
    logic [9:0] iCoord_Y;     // active-area row 0..479
    logic       iVGA_V_SYNC;  // active low
    logic [9:0] iDino_Y;      // dino top row from game logic
    logic [9:0] iObs_X;       // obstacle left column, >=640 is off-screen
    logic       iGame_Over;
    logic [9:0] oRed;
    logic [9:0] oGreen;
    logic [9:0] oBlue;

    modport master (
        output iCoord_X, iCoord_Y, iVGA_V_SYNC, iDino_Y, iObs_X, iGame_Over,
        input  oRed, oGreen, oBlue
    );

    modport slave (
        input  iCoord_X, iCoord_Y, iVGA_V_SYNC, iDino_Y, iObs_X, iGame_Over,
        output oRed, oGreen, oBlue
    );
endinterface

// File: rtl/dino_sprite_rom.sv
// Two independent 1-bit sprite ROMs: 2048x1 dino (two animation phases), 512x1 obstacle.
// Latency: 1 clock from address to data on both ports.
// Backpressure: none; a new address is accepted every clock.
// Ports: iCLK clock; dinoAddr/dinoDat dino port; obsAddr/obsDat obstacle port.
module dino_sprite_rom
    import dino_gfx_pkg::*;
(
    input  logic        iCLK,
    input  logic [10:0] dinoAddr,
    input  logic [8:0]  obsAddr,
    output logic        dinoDat,
    output logic        obsDat
);

    // Contents are constant functions of the address so the ROM folds into
    // lookup logic feeding a single output flop per port.
    always_ff @(posedge iCLK) begin
        dinoDat <= dinoPixel(dinoAddr);
        obsDat  <= obsPixel(obsAddr);
    end

endmodule

// File: rtl/dino_pixel_renderer.sv
// Per-pixel colour source for the VGA controller: dino, obstacle, scrolling ground, white sky.
// Latency: fixed 2 clocks from coordinate to RGB, one pixel per clock.
// Backpressure: none; never stalls. Game state is latched on the V-sync falling edge only.
// Ports: iCLK pixel clock; iRST sync active-high reset; bus = slave side of dino_pixel_renderer_if.
module dino_pixel_renderer
    import dino_gfx_pkg::*;
#(
    parameter int DINO_X       = 64,
    parameter int GROUND_Y     = 400,
    parameter int SCROLL_SPEED = 4,
    parameter int ANIM_FRAMES  = 8
)(
    input  logic                  iCLK,
    input  logic                  iRST,
    dino_pixel_renderer_if.slave  bus
);

    localparam int ACW     = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int OBS_TOP = GROUND_Y - (OBS_H - 1);

    // Frame-rate state
    logic           vsD;
    logic           frameTick;
    logic [9:0]     dinoYS;
    logic [9:0]     obsXS;
    logic           overS;
    logic [9:0]     scroll;
    logic [ACW-1:0] animCnt;
    logic           animPhase;

    // Stage 1
    logic [10:0] x11;
    logic [10:0] y11;
    logic        dinoHitC;
    logic        obsHitC;
    logic        gndC;
    logic [4:0]  dinoDx;
    logic [4:0]  dinoDy;
    logic [3:0]  obsDx;
    logic [4:0]  obsDy;
    logic [3:0]  scrolledLo;
    logic        dinoHitQ;
    logic        obsHitQ;
    logic        gndQ;
    logic        overQ;
    logic        dinoDat;
    logic        obsDat;

    // Stage 2
    rgb_t pixColour;
    rgb_t rgbQ;

    assign frameTick = vsD & ~bus.iVGA_V_SYNC;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            vsD       <= 1'b1;
            dinoYS    <= '0;
            obsXS     <= '0;
            overS     <= 1'b0;
            scroll    <= '0;
            animCnt   <= '0;
            animPhase <= 1'b0;
        end else begin
            vsD <= bus.iVGA_V_SYNC;
            if (frameTick) begin
                dinoYS <= bus.iDino_Y;
                obsXS  <= bus.iObs_X;
                overS  <= bus.iGame_Over;
                // Freeze decisions use the game-over state of the frame just ended.
                if (!overS) begin
                    scroll <= scroll + 10'(SCROLL_SPEED);
                    if (animCnt == ACW'(ANIM_FRAMES - 1)) begin
                        animCnt   <= '0;
                        animPhase <= ~animPhase;
                    end else begin
                        animCnt <= animCnt + 1'b1;
                    end
                end
            end
        end
    end

    // Box tests in 11 bits so a box whose far edge passes 1023 cannot wrap
    // back onto low coordinates.
    assign x11 = {1'b0, bus.iCoord_X};
    assign y11 = {1'b0, bus.iCoord_Y};

    assign dinoHitC = (x11 >= 11'(DINO_X)) && (x11 <= 11'(DINO_X + DINO_W - 1)) &&
                      (y11 >= {1'b0, dinoYS}) && (y11 <= {1'b0, dinoYS} + 11'(DINO_H - 1));
    assign obsHitC  = (x11 >= {1'b0, obsXS}) && (x11 <= {1'b0, obsXS} + 11'(OBS_W - 1)) &&
                      (y11 >= 11'(OBS_TOP)) && (y11 <= 11'(GROUND_Y));

    // Offsets only matter modulo the sprite size, so the low bits suffice.
    assign dinoDx = bus.iCoord_X[4:0] - 5'(DINO_X);
    assign dinoDy = bus.iCoord_Y[4:0] - dinoYS[4:0];
    assign obsDx  = bus.iCoord_X[3:0] - obsXS[3:0];
    assign obsDy  = bus.iCoord_Y[4:0] - 5'(OBS_TOP);

    // Bit 3 of the 10-bit X+scroll sum depends only on the low nibbles.
    assign scrolledLo = bus.iCoord_X[3:0] + scroll[3:0];
    assign gndC = (bus.iCoord_Y == 10'(GROUND_Y)) ||
                  ((bus.iCoord_Y >= 10'(GROUND_Y + 2)) && (bus.iCoord_Y <= 10'(GROUND_Y + 3)) &&
                   scrolledLo[3]);

    // The ROM's output register is the stage-1 register for the sprite bits.
    dino_sprite_rom u_rom (
        .iCLK     (iCLK),
        .dinoAddr ({animPhase, dinoDy, dinoDx}),
        .obsAddr  ({obsDy, obsDx}),
        .dinoDat  (dinoDat),
        .obsDat   (obsDat)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            dinoHitQ <= 1'b0;
            obsHitQ  <= 1'b0;
            gndQ     <= 1'b0;
            overQ    <= 1'b0;
        end else begin
            dinoHitQ <= dinoHitC;
            obsHitQ  <= obsHitC;
            gndQ     <= gndC;
            overQ    <= overS;  // travels with the pixel so a mid-pipe frame tick cannot recolour it
        end
    end

    // Zero sprite bits are transparent and fall through to lower layers.
    always_comb begin
        pixColour = COL_BG;
        if (dinoHitQ && dinoDat) begin
            pixColour = overQ ? COL_OVER_R : COL_DINO;
        end else if (obsHitQ && obsDat) begin
            pixColour = COL_OBS_G;
        end else if (gndQ) begin
            pixColour = COL_GND;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rgbQ <= '0;
        end else begin
            rgbQ <= pixColour;
        end
    end

    assign bus.oRed   = rgbQ.red;
    assign bus.oGreen = rgbQ.green;
    assign bus.oBlue  = rgbQ.blue;

endmodule
